// File: rtl/alu_seq_ctrl_if.sv
// Command/response channel bundle for alu_seq_ctrl.
// master: the side issuing commands and consuming results.
// slave : the controller.
interface alu_seq_ctrl_if #(
  parameter int N = 16
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a;
  logic [N-1:0] cmd_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_ovf;
  logic         rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_data, rsp_ovf, rsp_err
  );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Command-side sequencer for the combinational N-bit ALU.
// Takes an opcode plus two operands, drives the ALU control/operand pins,
// captures FUNC/Ovflag and returns the result on a valid/ready channel.
//
// Optional feature macro: ALU_SEQ_CTRL_MUL_EN
//   defined   -> op 4 (MUL) runs as b repeated ALU ADD passes
//   undefined -> op 4 is reported as an illegal opcode
module alu_seq_ctrl #(
  parameter int N = 16
) (
  input  logic          clk,
  input  logic          rst,
  alu_seq_ctrl_if.slave bus,
  output logic [N-1:0]  alu_a,
  output logic [N-1:0]  alu_b,
  output logic [N-1:0]  alu_reg0,
  output logic [N-1:0]  alu_reg1,
  output logic          alu_f0,
  output logic          alu_f1,
  output logic          alu_ena,
  output logic          alu_enb,
  output logic          alu_inva,
  output logic          alu_inc,
  input  logic [N-1:0]  alu_func,
  input  logic          alu_ovflag
);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_XOR = 3'd3;
`ifdef ALU_SEQ_CTRL_MUL_EN
  localparam logic [2:0] OP_MUL = 3'd4;
`endif

  // {F1,F0} function selects of the attached ALU
  localparam logic [1:0] FSEL_ADD = 2'b00;
  localparam logic [1:0] FSEL_OR  = 2'b01;
  localparam logic [1:0] FSEL_AND = 2'b10;
  localparam logic [1:0] FSEL_XOR = 2'b11;

`ifdef ALU_SEQ_CTRL_MUL_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    MUL  = 2'd2,
    RESP = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd3
  } state_t;
`endif

  state_t       state_q, state_d;

  logic         rsp_valid_q, rsp_valid_d;
  logic [N-1:0] rsp_data_q,  rsp_data_d;
  logic         rsp_ovf_q,   rsp_ovf_d;
  logic         rsp_err_q,   rsp_err_d;

  // Registered ALU drive. During MUL the alu_a register is the running
  // accumulator: it is reloaded from FUNC every pass, so no separate copy
  // of the partial product is kept.
  logic [1:0]   fsel_q,   fsel_d;
  logic [N-1:0] pin_a_q,  pin_a_d;
  logic [N-1:0] pin_b_q,  pin_b_d;
  logic [N-1:0] pin_r1_q, pin_r1_d;

`ifdef ALU_SEQ_CTRL_MUL_EN
  logic [N-1:0] mul_a_q,  mul_a_d;
  logic [N-1:0] count_q,  count_d;
  logic         sticky_q, sticky_d;
`endif

  // Only IDLE takes commands; everything else ignores the command channel.
  assign bus.cmd_ready = (state_q == IDLE);

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.rsp_err   = rsp_err_q;

  assign alu_f0   = fsel_q[0];
  assign alu_f1   = fsel_q[1];
  assign alu_a    = pin_a_q;
  assign alu_b    = pin_b_q;
  assign alu_reg1 = pin_r1_q;

  // Operand selection never needs REG0, input gating, inversion or carry-in.
  assign alu_reg0 = '0;
  assign alu_ena  = 1'b0;
  assign alu_enb  = 1'b0;
  assign alu_inva = 1'b0;
  assign alu_inc  = 1'b0;

  // Next-state and next-output decode; ALU pins default to 0 so they are only
  // non-zero in a cycle whose state is EXEC or MUL.
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    fsel_d      = 2'b00;
    pin_a_d     = '0;
    pin_b_d     = '0;
    pin_r1_d    = '0;
`ifdef ALU_SEQ_CTRL_MUL_EN
    mul_a_d     = mul_a_q;
    count_d     = count_q;
    sticky_d    = sticky_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          case (bus.cmd_op)
            OP_ADD: begin
              fsel_d  = FSEL_ADD;
              pin_a_d = bus.cmd_a;
              pin_b_d = bus.cmd_b;
              state_d = EXEC;
            end
            OP_OR: begin
              fsel_d  = FSEL_OR;
              pin_a_d = bus.cmd_a;
              pin_b_d = bus.cmd_b;
              state_d = EXEC;
            end
            OP_AND: begin
              fsel_d  = FSEL_AND;
              pin_a_d = bus.cmd_a;
              pin_b_d = bus.cmd_b;
              state_d = EXEC;
            end
            OP_XOR: begin
              // the ALU's XOR path takes its first operand from REG1
              fsel_d   = FSEL_XOR;
              pin_b_d  = bus.cmd_b;
              pin_r1_d = bus.cmd_a;
              state_d  = EXEC;
            end
`ifdef ALU_SEQ_CTRL_MUL_EN
            OP_MUL: begin
              if (bus.cmd_b != '0) begin
                // first pass: 0 + a
                mul_a_d  = bus.cmd_a;
                count_d  = bus.cmd_b;
                sticky_d = 1'b0;
                fsel_d   = FSEL_ADD;
                pin_a_d  = '0;
                pin_b_d  = bus.cmd_a;
                state_d  = MUL;
              end else begin
                // x*0 needs no ALU pass at all
                rsp_valid_d = 1'b1;
                rsp_data_d  = '0;
                rsp_ovf_d   = 1'b0;
                rsp_err_d   = 1'b0;
                state_d     = RESP;
              end
            end
`endif
            default: begin
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_ovf_d   = 1'b0;
              rsp_err_d   = 1'b1;
              state_d     = RESP;
            end
          endcase
        end
      end

      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = alu_func;
        rsp_ovf_d   = alu_ovflag;
        rsp_err_d   = 1'b0;
        state_d     = RESP;
      end

`ifdef ALU_SEQ_CTRL_MUL_EN
      MUL: begin
        sticky_d = sticky_q | alu_ovflag;
        count_d  = count_q - N'(1);
        if (count_q == N'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = alu_func;
          rsp_ovf_d   = sticky_q | alu_ovflag;
          rsp_err_d   = 1'b0;
          state_d     = RESP;
        end else begin
          fsel_d  = FSEL_ADD;
          pin_a_d = alu_func;
          pin_b_d = mul_a_q;
        end
      end
`endif

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response and ALU-drive registers; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      fsel_q      <= 2'b00;
      pin_a_q     <= '0;
      pin_b_q     <= '0;
      pin_r1_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      fsel_q      <= fsel_d;
      pin_a_q     <= pin_a_d;
      pin_b_q     <= pin_b_d;
      pin_r1_q    <= pin_r1_d;
    end
  end

`ifdef ALU_SEQ_CTRL_MUL_EN
  // Multiplier iteration state: latched multiplicand, remaining passes and
  // sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_a_q  <= '0;
      count_q  <= '0;
      sticky_q <= 1'b0;
    end else begin
      mul_a_q  <= mul_a_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl with a stand-in combinational ALU.
// Honours ALU_SEQ_CTRL_MUL_EN the same way the design does.
module tb_alu_seq_ctrl;
  localparam int N = 16;

  logic clk = 1'b0;
  logic rst;

  alu_seq_ctrl_if #(.N(N)) bus();

  logic [N-1:0] alu_a, alu_b, alu_reg0, alu_reg1, alu_func;
  logic         alu_f0, alu_f1, alu_ena, alu_enb, alu_inva, alu_inc, alu_ovflag;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_reg0   (alu_reg0),
    .alu_reg1   (alu_reg1),
    .alu_f0     (alu_f0),
    .alu_f1     (alu_f1),
    .alu_ena    (alu_ena),
    .alu_enb    (alu_enb),
    .alu_inva   (alu_inva),
    .alu_inc    (alu_inc),
    .alu_func   (alu_func),
    .alu_ovflag (alu_ovflag)
  );

  // Stand-in ALU: add with carry-out as overflow, OR, AND, REG1 xor B.
  always_comb begin
    alu_func   = '0;
    alu_ovflag = 1'b0;
    case ({alu_f1, alu_f0})
      2'b00: {alu_ovflag, alu_func} = {1'b0, alu_a} + {1'b0, alu_b};
      2'b01: alu_func = alu_a | alu_b;
      2'b10: alu_func = alu_a & alu_b;
      default: alu_func = alu_reg1 ^ alu_b;
    endcase
  end

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
    end
  endtask

  // Result model: data, overflow, error and number of ALU-busy cycles.
  function automatic void model(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] d, output logic o, output logic e,
                                output int cyc);
    longint unsigned p;
    d = '0; o = 1'b0; e = 1'b0; cyc = 0;
    case (op)
      3'd0: begin
        p = longint'(a) + longint'(b);
        d = N'(p); o = (p >= 64'd65536); cyc = 1;
      end
      3'd1: begin d = a | b; cyc = 1; end
      3'd2: begin d = a & b; cyc = 1; end
      3'd3: begin d = a ^ b; cyc = 1; end
`ifdef ALU_SEQ_CTRL_MUL_EN
      3'd4: begin
        p = longint'(a) * longint'(b);
        d = N'(p); o = (p >= 64'd65536); cyc = int'(b);
      end
`endif
      default: begin e = 1'b1; end
    endcase
  endfunction

  // Expected ALU drive during busy cycle k of a command.
  function automatic void exp_pins(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                   input int k, output logic [1:0] f, output logic [N-1:0] pa,
                                   output logic [N-1:0] pb, output logic [N-1:0] pr);
    f = op[1:0]; pa = a; pb = b; pr = '0;
    if (op == 3'd3) begin
      pa = '0; pr = a;
    end else if (op == 3'd4) begin
      f = 2'b00; pa = N'(longint'(a) * longint'(k)); pb = a;
    end
  endfunction

  task automatic check_pins(input string tag, input logic [1:0] f, input logic [N-1:0] pa,
                            input logic [N-1:0] pb, input logic [N-1:0] pr);
    check({tag, "_ctl"}, N'({alu_f1, alu_f0, alu_ena, alu_enb, alu_inva, alu_inc}), N'({f, 4'b0000}));
    check({tag, "_reg0"}, alu_reg0, '0);
    check({tag, "_a"}, alu_a, pa);
    check({tag, "_b"}, alu_b, pb);
    check({tag, "_reg1"}, alu_reg1, pr);
  endtask

  task automatic check_idle_zero(input string tag);
    check_bit({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    check_bit({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_data"}, bus.rsp_data, '0);
    check_bit({tag, "_rsp_ovf"}, bus.rsp_ovf, 1'b0);
    check_bit({tag, "_rsp_err"}, bus.rsp_err, 1'b0);
    check_pins(tag, 2'b00, '0, '0, '0);
  endtask

  // One full transaction from a negedge in IDLE back to the next IDLE negedge.
  task automatic do_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                        input int hold);
    logic [N-1:0] ed, pa, pb, pr;
    logic         eo, ee;
    logic [1:0]   f;
    int           cyc;
    model(op, a, b, ed, eo, ee, cyc);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.rsp_ready = 1'b0;
    check_bit("accept_cmd_ready", bus.cmd_ready, 1'b1);
    @(posedge clk); @(negedge clk);
    for (int k = 0; k < cyc; k++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_op    = 3'($urandom);
      bus.cmd_a     = N'($urandom);
      bus.cmd_b     = N'($urandom);
      bus.rsp_ready = 1'($urandom_range(0, 1));
      check_bit("busy_cmd_ready", bus.cmd_ready, 1'b0);
      check_bit("busy_rsp_valid", bus.rsp_valid, 1'b0);
      exp_pins(op, a, b, k, f, pa, pb, pr);
      check_pins("busy_pins", f, pa, pb, pr);
      @(posedge clk); @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      check_bit("resp_valid", bus.rsp_valid, 1'b1);
      check("resp_data", bus.rsp_data, ed);
      check_bit("resp_ovf", bus.rsp_ovf, eo);
      check_bit("resp_err", bus.rsp_err, ee);
      check_bit("resp_cmd_ready", bus.cmd_ready, 1'b0);
      check_pins("resp_pins", 2'b00, '0, '0, '0);
      if (h < hold) begin
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'($urandom_range(0, 1));
        bus.cmd_op    = 3'd2;
        bus.cmd_a     = N'($urandom);
        bus.cmd_b     = N'($urandom);
        @(posedge clk); @(negedge clk);
      end
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_bit("done_rsp_valid", bus.rsp_valid, 1'b0);
    check_bit("done_cmd_ready", bus.cmd_ready, 1'b1);
  endtask

  // Start a command, let it run a few cycles, then reset and verify it is gone.
  task automatic reset_mid(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                           input int run);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.rsp_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (run) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rstmid");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      check_bit("rstmid_no_rsp", bus.rsp_valid, 1'b0);
      check_pins("rstmid_quiet", 2'b00, '0, '0, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] md;
    logic         mo, me;
    int           mc;
    logic [2:0]   op;
    logic [N-1:0] a, b;

    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset");

    // pin the model to hand-computed values
    model(3'd0, 16'h0005, 16'h0003, md, mo, me, mc);
    check("model_add", md, 16'h0008);  check_bit("model_add_ovf", mo, 1'b0);
    model(3'd0, 16'hFFFF, 16'h0001, md, mo, me, mc);
    check("model_add_wrap", md, 16'h0000); check_bit("model_add_wrap_ovf", mo, 1'b1);
    model(3'd1, 16'h00F0, 16'h0F00, md, mo, me, mc);
    check("model_or", md, 16'h0FF0);
    model(3'd2, 16'h00FF, 16'h0F0F, md, mo, me, mc);
    check("model_and", md, 16'h000F);
    model(3'd3, 16'hAAAA, 16'hFFFF, md, mo, me, mc);
    check("model_xor", md, 16'h5555);
    model(3'd6, 16'h1234, 16'h5678, md, mo, me, mc);
    check_bit("model_op6_err", me, 1'b1); check("model_op6_data", md, 16'h0000);
`ifdef ALU_SEQ_CTRL_MUL_EN
    model(3'd4, 16'd7, 16'd6, md, mo, me, mc);
    check("model_mul", md, 16'd42); check("model_mul_cyc", N'(mc), 16'd6);
    model(3'd4, 16'h4000, 16'd4, md, mo, me, mc);
    check("model_mul_wrap", md, 16'h0000); check_bit("model_mul_wrap_ovf", mo, 1'b1);
`else
    model(3'd4, 16'd7, 16'd6, md, mo, me, mc);
    check_bit("model_op4_err", me, 1'b1); check("model_op4_data", md, 16'h0000);
`endif

    // directed transactions
    do_cmd(3'd0, 16'h0005, 16'h0003, 0);
    do_cmd(3'd0, 16'hFFFF, 16'h0001, 0);
    do_cmd(3'd1, 16'h00F0, 16'h0F00, 0);
    do_cmd(3'd2, 16'h00FF, 16'h0F0F, 0);
    do_cmd(3'd3, 16'hAAAA, 16'hFFFF, 0);
    do_cmd(3'd4, 16'd7, 16'd6, 0);
    do_cmd(3'd4, 16'h4000, 16'd4, 0);
    do_cmd(3'd4, 16'h1234, 16'd0, 0);
    do_cmd(3'd0, 16'd1, 16'd2, 10);
    do_cmd(3'd2, 16'h0F0F, 16'h00FF, 0);
    do_cmd(3'd6, 16'h1234, 16'h5678, 2);
    do_cmd(3'd7, 16'hFFFF, 16'hFFFF, 0);

`ifdef ALU_SEQ_CTRL_MUL_EN
    reset_mid(3'd4, 16'd3, 16'd1000, 5);
`else
    reset_mid(3'd6, 16'd3, 16'd1000, 5);
`endif

    // randomized traffic
    for (int t = 0; t < 150; t++) begin
      op = 3'($urandom_range(0, 7));
      a  = N'($urandom);
      b  = N'($urandom);
      case ($urandom_range(0, 5))
        0: a = 16'hFFFF;
        1: b = 16'hFFFF;
        2: a = '0;
        default: ;
      endcase
      if (op == 3'd4) b = N'($urandom_range(0, 40));
      do_cmd(op, a, b, int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Command-side initiator for the combinational 16-bit ALU.
- Accepts opcode and operand commands over a valid/ready handshake and drives the ALU control and operand pins (F0, F1, ENA, ENB, INVA, INC, A, B, Reg0, Reg1).
- Captures FUNC/Ovflag and returns the result over a valid/ready response channel.
- Adds a multi-cycle MUL implemented as iterated ALU ADD passes.

Parameters:
- N, 16, datapath width; must match the attached ALU's N.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  3  0=ADD, 1=OR, 2=AND, 3=XOR, 4=MUL, 5..7 illegal.
- cmd_a  in  N  operand A.
- cmd_b  in  N  operand B.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer takes the result.
- rsp_data  out  N  result.
- rsp_ovf  out  1  overflow; sticky across MUL iterations.
- rsp_err  out  1  illegal opcode.
- alu_a, alu_b, alu_reg0, alu_reg1  out  N  ALU operand pins.
- alu_f0, alu_f1, alu_ena, alu_enb, alu_inva, alu_inc  out  1  ALU control pins.
- alu_func  in  N  ALU result.
- alu_ovflag  in  1  ALU overflow.

Behaviour:
- FSM states: IDLE, EXEC, MUL, RESP. All outputs registered except cmd_ready, which is 1 exactly in IDLE.
- Reset, from any state including mid-MUL: state=IDLE; rsp_valid=0, rsp_data=0, rsp_ovf=0, rsp_err=0. All alu_* outputs 0. Internal acc and count cleared; an in-flight command is dropped.
- IDLE: when cmd_valid and cmd_ready, latch op, a and b.
  - Legal op other than MUL → EXEC.
  - MUL with b!=0 → MUL.
  - MUL with b==0 → RESP with data 0, ovf 0.
  - Illegal op → RESP with data 0, err 1; ALU pins are not driven.
- ALU pins outside EXEC and MUL: all 0. INC is always 0; INVA, ENA and ENB are always 0.
- Control words, {F1,F0}, with reg0=0 in every case:
  - ADD: 00, alu_a=a, alu_b=b, reg1=0.
  - OR: 01, alu_a=a, alu_b=b, reg1=0.
  - AND: 10, alu_a=a, alu_b=b, reg1=0.
  - XOR: 11, alu_a=0, alu_b=b, reg1=a.
- EXEC: one cycle.
  - Drive the control word.
  - At the end of the cycle, capture rsp_data=alu_func and rsp_ovf=alu_ovflag.
  - Go to RESP.
  - Latency: handshake at edge T → rsp_valid=1 after edge T+2.
- MUL: count=b, acc=0, each cycle:
  - Drive ADD with alu_a=acc and alu_b=a_latched.
  - acc<=alu_func; ovf_sticky|=alu_ovflag; count<=count-1.
  - When count==1, load rsp_data from alu_func and rsp_ovf from the final sticky value, then go to RESP.
  - Latency: b+1 edges from accept to rsp_valid.
  - Result is the product mod 2^N. Any wrap sets rsp_ovf.
- RESP: rsp_valid=1. rsp_data, rsp_ovf and rsp_err are held stable until rsp_ready=1.
  - On that edge, rsp_valid=0 and state=IDLE.
  - A new command can be accepted no earlier than the following cycle; there are no back-to-back overlaps.
- cmd_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Optional Feature:
- Macro: ALU_SEQ_CTRL_MUL_EN.
- Defined: MUL state and op 4 behave as above.
- Undefined: MUL state, acc and count logic are not built. Op 4 is treated as illegal (RESP, data 0, err 1, ALU pins untouched).

Test Plan:
- Reset while in MUL with a=3, b=1000 after 5 cycles → next cycle: cmd_ready=1, rsp_valid=0, all alu_* outputs = 0; no response is ever produced.
- ADD a=0x0005, b=0x0003, rsp_ready=1 → EXEC pins {F1,F0}=00, reg0=0; rsp_valid two edges after accept; rsp_data=0x0008, ovf=0. Then ADD 0xFFFF+0x0001 → data=0x0000, ovf=1.
- OR 0x00F0,0x0F00 → 0x0FF0. AND 0x00FF,0x0F0F → 0x000F. XOR a=0xAAAA, b=0xFFFF with alu_a=0 and reg1=0xAAAA → 0x5555. Each has err=0.
- MUL a=7, b=6 (ALU_SEQ_CTRL_MUL_EN defined) → 6 ADD iterations seen on pins; rsp_data=42 at accept+7 edges. MUL a=0x4000, b=4 → data=0x0000, ovf=1. MUL b=0 → data=0 after 1 edge, no ALU activity.
- Backpressure: hold rsp_ready=0 for 10 cycles after ADD 1+2 → rsp_valid stays 1, data stays 3, cmd_ready stays 0. cmd_valid pulses with op=AND are ignored. Release → accepted; next command is accepted the following cycle.
- Op 6, and op 4 with the macro undefined → rsp_err=1, rsp_data=0, all alu_* outputs stay 0 throughout.
